sramlike_slave: RTL and testbench
=================================

SRAMLIKE_SLAVE -- requirements
Module: sramlike_slave

Interface
REQ-001 SHALL have parameter DELAY, default 3, meaning extra wait cycles before data_ok; legal range 1..15; used only when SRAMLIKE_SLAVE_DELAY_EN is defined.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  request valid from the sram-like master.
REQ-005 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-006 SHALL have port size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  write data, already lane-aligned by the master.
REQ-009 SHALL have port addr_ok  output  1  request accepted this cycle when req is also high.
REQ-010 SHALL have port data_ok  output  1  one-cycle response strobe.
REQ-011 SHALL have port rdata  output  32  read word, valid while data_ok is high.
REQ-012 SHALL have ports sram_en (output, 1), sram_wen (output, 4), sram_addr (output, 32) and sram_wdata (output, 32); these drive a synchronous SRAM.
REQ-013 SHALL have port sram_rdata  input  32  SRAM read data, valid one cycle after sram_en.

Function
REQ-014 SHALL implement the states IDLE, ACCESS, LATCH, WAIT (macro builds only) and RESP.
REQ-015 SHALL drive addr_ok = req in IDLE and in RESP, and 0 in every other state.
REQ-016 On handshake (req && addr_ok) at cycle T, SHALL register wr, size, addr and wdata, then enter ACCESS at T+1.
REQ-017 In ACCESS, SHALL drive sram_en=1, sram_addr={addr[31:2],2'b00}, sram_wdata=wdata, and sram_wen = wr ? byte-enable : 4'b0000.
REQ-018 SHALL drive sram_en=0 and sram_wen=0 in every state other than ACCESS.
REQ-019 SHALL derive the byte-enable from size and addr[1:0] as follows:
- byte: 1<<addr[1:0];
- half: addr[1] ? 4'b1100 : 4'b0011;
- word: 4'b1111.
REQ-020 Misaligned accesses (half with addr[0]=1; word with addr[1:0]≠0) and size=3 SHALL produce sram_wen=0, and SHALL still complete with a normal data_ok.
REQ-021 In LATCH (T+2), SHALL capture rdata = wr ? 0 : sram_rdata, holding the full word unshifted; the master does the extraction.
REQ-022 Without the macro, LATCH SHALL go to RESP, so data_ok is high at T+3.
REQ-023 In RESP, data_ok SHALL be 1 for exactly one cycle.
REQ-024 From RESP, SHALL go to ACCESS on a new handshake, otherwise to IDLE; back-to-back throughput is therefore one transaction per 3 cycles.
REQ-025 SHALL hold rdata stable from RESP until the next LATCH.
REQ-026 SHALL keep at most one transaction outstanding; req in ACCESS, LATCH or WAIT SHALL be ignored and not recorded.
REQ-027 SHALL treat reads and writes identically in timing.

Reset
REQ-028 While rst is high, SHALL force all of the following on the next edge, with addr_ok forced to 0 combinationally:
- state=IDLE;
- addr_ok=0, data_ok=0, rdata=0;
- sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0;
- delay counter=0.
REQ-029 Reset in any state, including mid-transaction, SHALL abandon the transaction: no data_ok, and no sram_en in the cycle after reset.
REQ-030 In the first cycle after rst falls, a req SHALL be accepted.

Configuration
REQ-031 SHALL recognise macro SRAMLIKE_SLAVE_DELAY_EN.
REQ-032 With SRAMLIKE_SLAVE_DELAY_EN defined, LATCH SHALL go to WAIT and load a 4-bit counter with DELAY.
- The counter decrements each cycle; WAIT goes to RESP when it reaches 1.
- data_ok therefore arrives at T+3+DELAY.
REQ-033 With SRAMLIKE_SLAVE_DELAY_EN undefined, SHALL build no WAIT state and no counter, and SHALL ignore DELAY.

Structure
REQ-034 Package sramlike_pkg SHALL hold:
- constants SIZE_BYTE, SIZE_HALF, SIZE_WORD;
- the state enum typedef;
- the byte-enable/misalign function.
REQ-035 Sub-module sramlike_wen_gen SHALL be combinational: inputs size and addr[1:0]; outputs wen[3:0] and misaligned.
REQ-036 The SRAM model SHALL be bench-only and SHALL NOT be instantiated inside sramlike_slave.

Verification
REQ-037 Word read: SRAM[0x100]=0xDEADBEEF, read of addr 0x100 size 2 handshake at T -> sram_en at T+1, data_ok at T+3, rdata=0xDEADBEEF.
REQ-038 Byte write: write addr 0x203 size 0 wdata 0x11223344 -> sram_wen=4'b1000 at T+1; a later read of 0x200 returns 0x11xxxxxx with the other bytes unchanged.
REQ-039 Misaligned half write: write addr 0x301 size 1 -> sram_wen=0, data_ok at T+3, and the SRAM is unchanged.
REQ-040 Back-to-back: req held high for 3 reads -> handshakes at T, T+3, T+6, and data_ok at T+3, T+6, T+9.
REQ-041 Reset mid-transaction: rst asserted in LATCH -> no data_ok, state IDLE, all outputs 0; a read issued afterwards completes normally.
REQ-042 Macro build, DELAY=5: word read -> data_ok at T+8, and addr_ok=0 from T+1 through T+7.

Source files
------------

// File: rtl/sramlike_pkg.sv
// ============================================================================
// Module   : sramlike_pkg
// Brief    : Shared size codes, FSM state type and byte-enable decode for the
//            sram-like slave. WAIT exists only with SRAMLIKE_SLAVE_DELAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sramlike_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    LATCH  = 3'd2,
    RESP   = 3'd3
`ifdef SRAMLIKE_SLAVE_DELAY_EN
    , WAIT = 3'd4
`endif
  } state_t;

  typedef struct packed {
    logic       misaligned;
    logic [3:0] wen;
  } wen_t;

  // Misaligned and reserved sizes decode to no lanes so the access is a no-op.
  function automatic wen_t wenDecode(input logic [1:0] size, input logic [1:0] addrLo);
    wen_t r;
    r.misaligned = 1'b0;
    r.wen        = 4'b0000;
    case (size)
      SIZE_BYTE: r.wen = 4'b0001 << addrLo;
      SIZE_HALF: begin
        if (addrLo[0]) r.misaligned = 1'b1;
        else           r.wen = addrLo[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        if (addrLo != 2'b00) r.misaligned = 1'b1;
        else                 r.wen = 4'b1111;
      end
      default: r.misaligned = 1'b1;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sramlike_wen_gen.sv
// ============================================================================
// Module   : sramlike_wen_gen
// Brief    : Combinational byte-enable and misalignment decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sramlike_wen_gen
  import sramlike_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addrLo,
  output logic [3:0] wen,
  output logic       misaligned
);

  wen_t w_dec;

  assign w_dec      = wenDecode(size, addrLo);
  assign wen        = w_dec.wen;
  assign misaligned = w_dec.misaligned;

endmodule

`default_nettype wire

// File: rtl/sramlike_slave.sv
// ============================================================================
// Module   : sramlike_slave
// Brief    : Sram-like bus slave driving a synchronous SRAM, one transaction
//            outstanding. SRAMLIKE_SLAVE_DELAY_EN adds DELAY wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sramlike_slave
  import sramlike_pkg::*;
#(
  parameter int DELAY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  state_t     r_state;
  logic       r_wr;
  logic [3:0] w_wen;
  logic       w_misaligned;
  logic       w_handshake;

`ifdef SRAMLIKE_SLAVE_DELAY_EN
  logic [3:0] r_cnt;
`else
  // DELAY has no effect in this build.
  localparam int c_unusedDelay = DELAY;
`endif

  sramlike_wen_gen u_wenGen (
    .size       (size),
    .addrLo     (addr[1:0]),
    .wen        (w_wen),
    .misaligned (w_misaligned)
  );

  assign addr_ok     = !rst && req && ((r_state == IDLE) || (r_state == RESP));
  assign w_handshake = addr_ok;

  // SRAM controls are registered at the handshake so they are live during ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr       <= 1'b0;
      data_ok    <= 1'b0;
      rdata      <= 32'h0;
      sram_en    <= 1'b0;
      sram_wen   <= 4'b0000;
      sram_addr  <= 32'h0;
      sram_wdata <= 32'h0;
`ifdef SRAMLIKE_SLAVE_DELAY_EN
      r_cnt      <= 4'd0;
`endif
    end else begin
      sram_en  <= 1'b0;
      sram_wen <= 4'b0000;
      data_ok  <= 1'b0;
      case (r_state)
        IDLE, RESP: begin
          if (w_handshake) begin
            r_state    <= ACCESS;
            r_wr       <= wr;
            sram_en    <= 1'b1;
            sram_wen   <= (wr && !w_misaligned) ? w_wen : 4'b0000;
            sram_addr  <= {addr[31:2], 2'b00};
            sram_wdata <= wdata;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: r_state <= LATCH;
        LATCH: begin
          rdata <= r_wr ? 32'h0 : sram_rdata;
`ifdef SRAMLIKE_SLAVE_DELAY_EN
          r_state <= WAIT;
          r_cnt   <= 4'(DELAY);
`else
          r_state <= RESP;
          data_ok <= 1'b1;
`endif
        end
`ifdef SRAMLIKE_SLAVE_DELAY_EN
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            data_ok <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sramlike_slave.sv
// ============================================================================
// Module   : tb_sramlike_slave
// Brief    : Self-checking bench for sramlike_slave with a bench-side SRAM and
//            a byte-level memory model. Honours SRAMLIKE_SLAVE_DELAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sramlike_slave;

  localparam int TB_DELAY = 5;
`ifdef SRAMLIKE_SLAVE_DELAY_EN
  localparam int LAT = 3 + TB_DELAY;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst, req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int errors = 0;
  int checks = 0;

  bit   [31:0] sramMem [0:1023];
  logic [31:0] sramQ = 32'h0;
  logic        preloadEn = 1'b0;
  logic [9:0]  preloadIdx = 10'h0;
  logic [31:0] preloadVal = 32'h0;
  bit   [31:0] expMem [0:1023];

  always #5 clk = ~clk;

  sramlike_slave #(.DELAY(TB_DELAY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wr         (wr),
    .size       (size),
    .addr       (addr),
    .wdata      (wdata),
    .addr_ok    (addr_ok),
    .data_ok    (data_ok),
    .rdata      (rdata),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Synchronous SRAM: read data appears the cycle after sram_en.
  assign sram_rdata = sramQ;
  always @(posedge clk) begin
    if (preloadEn) begin
      sramMem[preloadIdx] <= preloadVal;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) sramMem[sram_addr[11:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      sramQ <= sramMem[sram_addr[11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lanes touched by an access: n bytes starting at the low address bits,
  // legal only when the address is a multiple of the access size.
  function automatic logic [3:0] modelWen(input logic [1:0] sz, input logic [31:0] a);
    int lo, n;
    logic [3:0] m;
    lo = int'(a[1:0]);
    m  = 4'b0000;
    case (sz)
      2'd0:    n = 1;
      2'd1:    n = 2;
      2'd2:    n = 4;
      default: n = 0;
    endcase
    if (n != 0 && (lo % n) == 0)
      for (int b = lo; b < lo + n; b++) m[b] = 1'b1;
    return m;
  endfunction

  task automatic doTxn(input string tag, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    logic [3:0]  ew;
    logic [31:0] er;
    int          idx;
    ew  = w ? modelWen(sz, a) : 4'b0000;
    idx = int'(a[11:2]);
    er  = w ? 32'h0 : expMem[idx];
    if (w)
      for (int b = 0; b < 4; b++)
        if (ew[b]) expMem[idx][8*b +: 8] = d[8*b +: 8];

    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    #1;
    check({tag, " addr_ok"}, {31'h0, addr_ok}, 32'h1);
    @(posedge clk); #1;
    req = 1'b0; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    check({tag, " sram_en"}, {31'h0, sram_en}, 32'h1);
    check({tag, " sram_wen"}, {28'h0, sram_wen}, {28'h0, ew});
    check({tag, " sram_addr"}, sram_addr, {a[31:2], 2'b00});
    check({tag, " sram_wdata"}, sram_wdata, d);
    for (int k = 1; k < LAT; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      req = 1'($urandom);
      #1;
      check({tag, " busy addr_ok"}, {31'h0, addr_ok}, 32'h0);
      check({tag, " early data_ok"}, {31'h0, data_ok}, 32'h0);
    end
    @(posedge clk); #1;
    req = 1'b0;
    #1;
    check({tag, " data_ok"}, {31'h0, data_ok}, 32'h1);
    check({tag, " rdata"}, rdata, er);
    @(posedge clk); #1;
    check({tag, " data_ok pulse"}, {31'h0, data_ok}, 32'h0);
    check({tag, " rdata hold"}, rdata, er);
    check({tag, " sram_en idle"}, {31'h0, sram_en}, 32'h0);
  endtask

  task automatic backToBack(input logic [31:0] a0);
    logic [31:0] addrs [3];
    logic [31:0] er [3];
    for (int i = 0; i < 3; i++) begin
      addrs[i] = a0 + 32'(4 * i);
      er[i]    = expMem[int'(addrs[i][11:2])];
    end
    for (int c = 0; c <= 3 * LAT; c++) begin
      req  = (c <= 2 * LAT);
      wr   = 1'b0;
      size = 2'd2;
      addr = addrs[(c / LAT > 2) ? 2 : c / LAT];
      #1;
      check("b2b addr_ok", {31'h0, addr_ok}, {31'h0, (c % LAT == 0) && (c <= 2 * LAT)});
      check("b2b data_ok", {31'h0, data_ok}, {31'h0, (c % LAT == 0) && (c > 0)});
      if (c % LAT == 0 && c > 0) check("b2b rdata", rdata, er[c / LAT - 1]);
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic resetMid();
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h100;
    #1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b1;
    #1;
    check("rstmid addr_ok forced", {31'h0, addr_ok}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstmid data_ok", {31'h0, data_ok}, 32'h0);
    check("rstmid sram_en", {31'h0, sram_en}, 32'h0);
    check("rstmid sram_wen", {28'h0, sram_wen}, 32'h0);
    check("rstmid sram_addr", sram_addr, 32'h0);
    check("rstmid sram_wdata", sram_wdata, 32'h0);
    check("rstmid rdata", rdata, 32'h0);
    check("rstmid idle addr_ok", {31'h0, addr_ok}, 32'h1);
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
    preloadIdx = 10'h040; preloadVal = 32'hDEADBEEF; preloadEn = 1'b1;
    expMem[64] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    preloadEn = 1'b0;
    req = 1'b1;
    #1;
    check("reset addr_ok", {31'h0, addr_ok}, 32'h0);
    check("reset data_ok", {31'h0, data_ok}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset sram_en", {31'h0, sram_en}, 32'h0);
    check("reset sram_wen", {28'h0, sram_wen}, 32'h0);
    check("reset sram_addr", sram_addr, 32'h0);
    check("reset sram_wdata", sram_wdata, 32'h0);
    req = 1'b0;
    rst = 1'b0;

    doTxn("word_rd",     1'b0, 2'd2, 32'h0000_0100, 32'h0);
    doTxn("word_wr",     1'b1, 2'd2, 32'h0000_0200, 32'hA5A5_A5A5);
    doTxn("byte_wr",     1'b1, 2'd0, 32'h0000_0203, 32'h1122_3344);
    doTxn("byte_chk",    1'b0, 2'd2, 32'h0000_0200, 32'h0);
    doTxn("mis_half_wr", 1'b1, 2'd1, 32'h0000_0301, 32'hAABB_CCDD);
    doTxn("mis_half_rd", 1'b0, 2'd2, 32'h0000_0300, 32'h0);
    doTxn("size3_wr",    1'b1, 2'd3, 32'h0000_0304, 32'h5555_AAAA);
    doTxn("mis_word_wr", 1'b1, 2'd2, 32'h0000_0306, 32'h0F0F_0F0F);
    doTxn("half_hi_wr",  1'b1, 2'd1, 32'h0000_0402, 32'hBEEF_0000);
    doTxn("half_lo_wr",  1'b1, 2'd1, 32'h0000_0400, 32'h0000_CAFE);
    doTxn("half_chk",    1'b0, 2'd1, 32'h0000_0400, 32'h0);

    backToBack(32'h0000_0100);
    resetMid();
    doTxn("post_rst_rd", 1'b0, 2'd2, 32'h0000_0100, 32'h0);

    for (int i = 0; i < 40; i++)
      doTxn("rand", 1'($urandom), 2'($urandom), $urandom, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
